// File: rtl/id_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a one-entry
// valid/ready holding register, with load-use stall, flush and saturating statistics.
module id_stage #(
    parameter int XLEN   = 32,
    parameter int CNT_W  = 16,
    parameter bit STR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    input  logic             ex_load_valid,
    input  logic [4:0]       ex_load_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       opcode,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  imm,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             branch,
    output logic             jump,
    output logic             alu_imm,
    output logic             illegal,
    output logic [79:0]      decode_str,
    output logic [CNT_W-1:0] decode_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [6:0] OP_FENCE = 7'h0F;
    localparam logic [6:0] OP_SYS   = 7'h73;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            reg_we;
        logic            mem_rd;
        logic            mem_wr;
        logic            branch;
        logic            jump;
        logic            alu_imm;
        logic            illegal;
        logic [79:0]     str;
    } dec_t;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_fence, is_sys;
    logic known, bad, has_rd, uses_rs1, uses_rs2;
    logic [31:0]      imm32;
    logic [XLEN+31:0] imm_wide;
    logic [79:0]      mnem;
    dec_t             dec_next;

    dec_t             dec_reg;
    logic             held_reg;
    logic [XLEN-1:0]  pc_reg;
    logic [CNT_W-1:0] decode_cnt_reg;
    logic [CNT_W-1:0] illegal_cnt_reg;

    logic hazard, xfer, accept;

    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];

    assign is_r     = (op == OP_REG);
    assign is_i     = (op == OP_IMM);
    assign is_ld    = (op == OP_LOAD);
    assign is_st    = (op == OP_STORE);
    assign is_br    = (op == OP_BR);
    assign is_jal   = (op == OP_JAL);
    assign is_jalr  = (op == OP_JALR);
    assign is_lui   = (op == OP_LUI);
    assign is_auipc = (op == OP_AUIPC);
    assign is_fence = (op == OP_FENCE);
    assign is_sys   = (op == OP_SYS);

    assign known    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr |
                      is_lui | is_auipc | is_fence | is_sys;
    assign has_rd   = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc;
    assign uses_rs1 = is_r | is_i | is_ld | is_st | is_br | is_jalr;
    assign uses_rs2 = is_r | is_st | is_br;

    always_comb begin
        bad = !known;
        if (is_ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) bad = 1'b1;
        if (is_st && f3 >= 3'd3) bad = 1'b1;
        if (is_br && (f3 == 3'd2 || f3 == 3'd3)) bad = 1'b1;
        if (is_jalr && f3 != 3'd0) bad = 1'b1;
        if (is_r && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) bad = 1'b1;
        if (is_i && f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
        if (is_i && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
        if (is_sys && in_instr != 32'h0000_0073 && in_instr != 32'h0010_0073) bad = 1'b1;
    end

    always_comb begin
        imm32 = 32'd0;
        if (is_i && (f3 == 3'd1 || f3 == 3'd5))
            imm32 = {27'd0, in_instr[24:20]};
        else if (is_i || is_ld || is_jalr || is_fence || is_sys)
            imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        else if (is_st)
            imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (is_br)
            imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        else if (is_jal)
            imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        else if (is_lui || is_auipc)
            imm32 = {in_instr[31:12], 12'd0};
    end

    // Sign-extend through a double-width temporary so XLEN=32 needs no zero-width replication.
    assign imm_wide = {{XLEN{imm32[31]}}, imm32};

    always_comb begin
        mnem = 80'("UNKNOWN");
        case (op)
            OP_REG: case (f3)
                3'd0: mnem = f7[5] ? 80'("SUB") : 80'("ADD");
                3'd1: mnem = 80'("SLL");
                3'd2: mnem = 80'("SLT");
                3'd3: mnem = 80'("SLTU");
                3'd4: mnem = 80'("XOR");
                3'd5: mnem = f7[5] ? 80'("SRA") : 80'("SRL");
                3'd6: mnem = 80'("OR");
                default: mnem = 80'("AND");
            endcase
            OP_IMM: case (f3)
                3'd0: mnem = 80'("ADDI");
                3'd1: mnem = 80'("SLLI");
                3'd2: mnem = 80'("SLTI");
                3'd3: mnem = 80'("SLTIU");
                3'd4: mnem = 80'("XORI");
                3'd5: mnem = f7[5] ? 80'("SRAI") : 80'("SRLI");
                3'd6: mnem = 80'("ORI");
                default: mnem = 80'("ANDI");
            endcase
            OP_LOAD: case (f3)
                3'd0: mnem = 80'("LB");
                3'd1: mnem = 80'("LH");
                3'd2: mnem = 80'("LW");
                3'd4: mnem = 80'("LBU");
                3'd5: mnem = 80'("LHU");
                default: ;
            endcase
            OP_STORE: case (f3)
                3'd0: mnem = 80'("SB");
                3'd1: mnem = 80'("SH");
                3'd2: mnem = 80'("SW");
                default: ;
            endcase
            OP_BR: case (f3)
                3'd0: mnem = 80'("BEQ");
                3'd1: mnem = 80'("BNE");
                3'd4: mnem = 80'("BLT");
                3'd5: mnem = 80'("BGE");
                3'd6: mnem = 80'("BLTU");
                3'd7: mnem = 80'("BGEU");
                default: ;
            endcase
            OP_JAL:   mnem = 80'("JAL");
            OP_JALR:  mnem = 80'("JALR");
            OP_LUI:   mnem = 80'("LUI");
            OP_AUIPC: mnem = 80'("AUIPC");
            OP_FENCE: mnem = 80'("FENCE");
            OP_SYS:   mnem = in_instr[20] ? 80'("EBREAK") : 80'("ECALL");
            default: ;
        endcase
        if (bad) mnem = 80'("UNKNOWN");
    end

    always_comb begin
        dec_next         = '0;
        dec_next.opcode  = op;
        dec_next.func3   = f3;
        dec_next.func7   = f7;
        dec_next.rd      = has_rd   ? in_instr[11:7]  : 5'd0;
        dec_next.rs1     = uses_rs1 ? in_instr[19:15] : 5'd0;
        dec_next.rs2     = uses_rs2 ? in_instr[24:20] : 5'd0;
        dec_next.imm     = imm_wide[XLEN-1:0];
        dec_next.reg_we  = !bad && has_rd && (in_instr[11:7] != 5'd0);
        dec_next.mem_rd  = !bad && is_ld;
        dec_next.mem_wr  = !bad && is_st;
        dec_next.branch  = !bad && is_br;
        dec_next.jump    = !bad && (is_jal || is_jalr);
        dec_next.alu_imm = !bad && (is_i || is_ld || is_st || is_jalr || is_lui || is_auipc);
        dec_next.illegal = bad;
        dec_next.str     = mnem;
    end

    // rs1/rs2 are zeroed for formats that do not read them, and rd==0 never stalls,
    // so a plain index match is equivalent to gating with the per-format use flags.
    assign hazard    = ex_load_valid && (ex_load_rd != 5'd0) &&
                       ((dec_reg.rs1 == ex_load_rd) || (dec_reg.rs2 == ex_load_rd));
    assign out_valid = !reset && held_reg && !hazard;
    assign xfer      = out_valid && out_ready;
    assign in_ready  = !reset && !flush && (!held_reg || xfer);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            held_reg        <= 1'b0;
            pc_reg          <= '0;
            dec_reg         <= '0;
            decode_cnt_reg  <= '0;
            illegal_cnt_reg <= '0;
        end else begin
            if (accept) begin
                held_reg <= 1'b1;
                pc_reg   <= in_pc;
                dec_reg  <= dec_next;
            end else if (flush || xfer) begin
                held_reg <= 1'b0;
            end
            if (xfer && !flush) begin
                if (decode_cnt_reg != '1)
                    decode_cnt_reg <= decode_cnt_reg + CNT_W'(1);
                if (dec_reg.illegal && illegal_cnt_reg != '1)
                    illegal_cnt_reg <= illegal_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign out_pc      = pc_reg;
    assign opcode      = dec_reg.opcode;
    assign func3       = dec_reg.func3;
    assign func7       = dec_reg.func7;
    assign rd          = dec_reg.rd;
    assign rs1         = dec_reg.rs1;
    assign rs2         = dec_reg.rs2;
    assign imm         = dec_reg.imm;
    assign reg_we      = dec_reg.reg_we;
    assign mem_rd      = dec_reg.mem_rd;
    assign mem_wr      = dec_reg.mem_wr;
    assign branch      = dec_reg.branch;
    assign jump        = dec_reg.jump;
    assign alu_imm     = dec_reg.alu_imm;
    assign illegal     = dec_reg.illegal;
    assign decode_cnt  = decode_cnt_reg;
    assign illegal_cnt = illegal_cnt_reg;

    generate
        if (STR_EN) begin : gen_str
            assign decode_str = reset     ? 80'("RESET")  :
                                !held_reg ? 80'("BUBBLE") : dec_reg.str;
        end else begin : gen_no_str
            assign decode_str = 80'd0;
        end
    endgenerate
endmodule
